mem_wb: RTL and testbench

//  Memory-access/writeback stage directly upstream of the register file write port.

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/load_align.sv | 29 ++
 rtl/mem_wb.sv | 150 +++++++++++++++
 tb/tb_mem_wb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and helpers for the memory/writeback stage: FSM encoding, RV32I
// load/store size codes and store lane helpers.
package riscv_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StWb   = 2'd3
    } state_e;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // Store sizes other than byte/halfword fall back to a full word.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3)
            FUNCT3_B: store_mask = 4'b0001 << a;
            FUNCT3_H: store_mask = 4'b0011 << {a[1], 1'b0};
            default:  store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] d);
        case (funct3)
            FUNCT3_B: store_data = {4{d[7:0]}};
            FUNCT3_H: store_data = {2{d[15:0]}};
            default:  store_data = d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] a,
                                        input logic is_load);
        case (funct3)
            FUNCT3_B:  misaligned = 1'b0;
            FUNCT3_H:  misaligned = a[0];
            FUNCT3_BU: misaligned = is_load ? 1'b0 : (a != 2'b00);
            FUNCT3_HU: misaligned = is_load ? a[0] : (a != 2'b00);
            default:   misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_rdata >> {i_addr, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_funct3)
            FUNCT3_B:  o_data = {{24{w_byte[7]}}, w_byte};
            FUNCT3_BU: o_data = {24'd0, w_byte};
            FUNCT3_H:  o_data = {{16{w_half[15]}}, w_half};
            FUNCT3_HU: o_data = {16'd0, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// Memory-access / writeback stage feeding the register file write port.
// Define MEM_WB_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module mem_wb
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_rd_wen,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [2:0]  i_funct3,
    output logic        o_dmem_req,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_waddr,
    output logic [31:0] o_rd_wdata,
    output logic        o_err
);

    state_e      r_state, w_state_next;
    logic [31:0] r_addr, r_wdata, r_wb_data, r_wait;
    logic [3:0]  r_mask;
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd_addr;
    logic        r_rd_wen, r_is_store, r_trap;
    logic        w_accept, w_is_mem, w_misalign, w_active, w_timeout, w_capture;
    logic [31:0] w_load_data;

    assign o_ready   = (r_state == StIdle) || (r_state == StWb);
    assign w_accept  = i_valid && o_ready;
    assign w_is_mem  = i_mem_ren || i_mem_wen;
    assign w_active  = (r_state == StReq) || (r_state == StWait);
    assign w_timeout = (MAX_WAIT != 0) && w_active && (r_wait == MAX_WAIT);

`ifdef MEM_WB_MISALIGN_TRAP_EN
    assign w_misalign = w_is_mem && misaligned(i_funct3, i_alu_result[1:0], i_mem_ren);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            StIdle, StWb: begin
                if (!w_accept) begin
                    w_state_next = StIdle;
                end else if (w_is_mem && !w_misalign) begin
                    w_state_next = StReq;
                end else begin
                    w_state_next = StWb;
                end
            end
            StReq: begin
                if (w_timeout) begin
                    w_state_next = StIdle;
                end else if (i_dmem_ready) begin
                    if (r_is_store) begin
                        w_state_next = StIdle;
                    end else if (i_dmem_rvalid) begin
                        w_state_next = StWb;
                        w_capture    = 1'b1;
                    end else begin
                        w_state_next = StWait;
                    end
                end
            end
            StWait: begin
                if (w_timeout) begin
                    w_state_next = StIdle;
                end else if (i_dmem_rvalid) begin
                    w_state_next = StWb;
                    w_capture    = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_wait     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wb_data  <= '0;
            r_mask     <= '0;
            r_lane     <= '0;
            r_funct3   <= '0;
            r_rd_addr  <= '0;
            r_rd_wen   <= 1'b0;
            r_is_store <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Counts total cycles across REQ and WAIT; cleared once the access ends.
            if (w_active && (w_state_next == StReq || w_state_next == StWait)) begin
                r_wait <= r_wait + 32'd1;
            end else begin
                r_wait <= '0;
            end
            if (w_accept) begin
                r_addr     <= {i_alu_result[31:2], 2'b00};
                r_lane     <= i_alu_result[1:0];
                r_wdata    <= store_data(i_funct3, i_store_data);
                r_mask     <= store_mask(i_funct3, i_alu_result[1:0]);
                r_funct3   <= i_funct3;
                r_rd_addr  <= i_rd_addr;
                r_rd_wen   <= i_rd_wen && (i_rd_addr != 5'd0) && !i_mem_wen && !w_misalign;
                r_is_store <= i_mem_wen;
                r_trap     <= w_misalign;
                r_wb_data  <= i_alu_result;
            end else if (w_capture) begin
                r_wb_data  <= w_load_data;
            end
        end
    end

    load_align u_load_align (
        .i_rdata  (i_dmem_rdata),
        .i_addr   (r_lane),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    assign o_dmem_req   = (r_state == StReq) && !w_timeout;
    assign o_dmem_addr  = r_addr;
    assign o_dmem_wen   = o_dmem_req && r_is_store;
    assign o_dmem_wdata = r_wdata;
    assign o_dmem_mask  = r_mask;
    assign o_rd_wen     = (r_state == StWb) && r_rd_wen;
    assign o_rd_waddr   = r_rd_addr;
    assign o_rd_wdata   = r_wb_data;
    assign o_err        = w_timeout || ((r_state == StWb) && r_trap);

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed cases plus random ops against a size/offset model.
module tb_mem_wb;

    localparam int unsigned MaxWait = 4;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic        i_clk, i_rst, i_valid, o_ready;
    logic [31:0] i_alu_result, i_store_data;
    logic [4:0]  i_rd_addr;
    logic        i_rd_wen, i_mem_ren, i_mem_wen;
    logic [2:0]  i_funct3;
    logic        o_dmem_req, o_dmem_wen, i_dmem_ready, i_dmem_rvalid;
    logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
    logic [3:0]  o_dmem_mask;
    logic        o_rd_wen, o_err;
    logic [4:0]  o_rd_waddr;
    logic [31:0] o_rd_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb #(.MAX_WAIT(MaxWait)) u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_alu_result  (i_alu_result),
        .i_store_data  (i_store_data),
        .i_rd_addr     (i_rd_addr),
        .i_rd_wen      (i_rd_wen),
        .i_mem_ren     (i_mem_ren),
        .i_mem_wen     (i_mem_wen),
        .i_funct3      (i_funct3),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wen    (o_dmem_wen),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_mask   (o_dmem_mask),
        .i_dmem_ready  (i_dmem_ready),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_rd_wen      (o_rd_wen),
        .o_rd_waddr    (o_rd_waddr),
        .o_rd_wdata    (o_rd_wdata),
        .o_err         (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Access size in bytes; unknown codes (and BU/HU on stores) mean a word.
    function automatic int unsigned acc_size(input logic [2:0] f3, input bit is_load);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd4:    return is_load ? 1 : 4;
            3'd5:    return is_load ? 2 : 4;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] a,
                                             input logic [2:0] f3);
        int unsigned sz, off;
        logic [31:0] v;
        sz  = acc_size(f3, 1'b1);
        off = ((a % 4) / sz) * sz;
        v   = rdata >> (8 * off);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int unsigned sz);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Called at a negedge with the DUT able to accept; returns at the negedge where the
    // op's final cycle (WB, or IDLE after a store) is visible.
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic rdw, input logic [2:0] f3,
                         input logic [31:0] rdata, input int rdy_dly, input int rv_dly);
        bit is_load, is_store, trap, exp_wen, done;
        int unsigned sz, off;
        logic [31:0] exp_wd;
        int c;
        is_load  = (kind == 1);
        is_store = (kind == 2);
        sz       = acc_size(f3, is_load);
        off      = ((addr % 4) / sz) * sz;
        trap     = Trap && (is_load || is_store) && ((addr % sz) != 0);
        exp_wen  = !is_store && !trap && rdw && (rd != 5'd0);
        exp_wd   = is_load ? exp_load(rdata, addr, f3) : addr;

        check_eq("ready_accept", o_ready, 1);
        i_valid = 1'b1; i_alu_result = addr; i_store_data = sdata; i_rd_addr = rd;
        i_rd_wen = rdw; i_mem_ren = is_load; i_mem_wen = is_store; i_funct3 = f3;
        @(negedge i_clk);
        i_valid = 1'b0; i_alu_result = $urandom; i_store_data = $urandom;
        i_rd_addr = 5'($urandom); i_funct3 = 3'($urandom);

        if ((is_load || is_store) && !trap) begin
            c = 0;
            done = 1'b0;
            while (!done && c < 16) begin
                if (c <= rdy_dly) begin
                    check_eq("dmem_req", o_dmem_req, 1);
                    check_eq("dmem_addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
                    check_eq("dmem_wen", o_dmem_wen, is_store);
                    if (is_store) begin
                        check_eq("dmem_mask", o_dmem_mask, ((32'd1 << sz) - 1) << off);
                        check_eq("dmem_wdata", o_dmem_wdata, exp_wdata(sdata, sz));
                    end
                end
                check_eq("rd_wen_busy", o_rd_wen, 0);
                i_dmem_ready  = (c == rdy_dly);
                i_dmem_rvalid = is_load && (c == rdy_dly + rv_dly);
                i_dmem_rdata  = i_dmem_rvalid ? rdata : $urandom;
                done = is_store ? (c == rdy_dly) : (c == rdy_dly + rv_dly);
                @(negedge i_clk);
                c++;
            end
            i_dmem_ready  = 1'b0;
            i_dmem_rvalid = 1'b0;
            if (is_store) begin
                check_eq("st_req_done", o_dmem_req, 0);
                check_eq("st_no_rd", o_rd_wen, 0);
                check_eq("st_idle", o_ready, 1);
            end
        end
        if (!is_store || trap) begin
            check_eq("wb_wen", o_rd_wen, exp_wen);
            if (exp_wen) begin
                check_eq("wb_addr", o_rd_waddr, rd);
                check_eq("wb_data", o_rd_wdata, exp_wd);
            end
            check_eq("wb_err", o_err, trap);
            check_eq("wb_req", o_dmem_req, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ld_f3 [6];
        logic [2:0] st_f3 [5];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
        st_f3 = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd7};

        i_rst = 1'b1; i_valid = 1'b0; i_alu_result = '0; i_store_data = '0;
        i_rd_addr = '0; i_rd_wen = 1'b0; i_mem_ren = 1'b0; i_mem_wen = 1'b0;
        i_funct3 = '0; i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        repeat (2) @(negedge i_clk);
        check_eq("rst_ready", o_ready, 1);
        check_eq("rst_req", o_dmem_req, 0);
        check_eq("rst_rd_wen", o_rd_wen, 0);
        check_eq("rst_err", o_err, 0);
        check_eq("rst_wdata", o_rd_wdata, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        do_op(0, 32'hDEAD_BEEF, 0, 5'd5, 1'b1, 3'd0, 0, 0, 0);
        do_op(0, 32'h1234_5678, 0, 5'd0, 1'b1, 3'd0, 0, 0, 0);
        do_op(1, 32'h0000_0103, 0, 5'd7, 1'b1, 3'd0, 32'h8000_0000, 0, 3);
        do_op(1, 32'h0000_0103, 0, 5'd8, 1'b1, 3'd4, 32'h8000_0000, 1, 2);
        do_op(2, 32'h0000_0202, 32'h1234_ABCD, 5'd3, 1'b1, 3'd1, 0, 2, 0);
        do_op(1, 32'h0000_0006, 0, 5'd9, 1'b1, 3'd2, 32'hCAFE_F00D, 0, 0);
        do_op(1, 32'h0000_0042, 0, 5'd0, 1'b1, 3'd1, 32'h8001_7FFF, 0, 1);

        for (int i = 0; i < 60; i++) begin
            int kind, rdy, rv;
            kind = $urandom_range(0, 2);
            rdy  = $urandom_range(0, 1);
            rv   = $urandom_range(0, 2);
            do_op(kind, $urandom, $urandom, 5'($urandom), 1'($urandom),
                  (kind == 2) ? st_f3[$urandom_range(0, 4)] : ld_f3[$urandom_range(0, 5)],
                  $urandom, rdy, rv);
            if ($urandom_range(0, 1) == 1) @(negedge i_clk);
        end
        @(negedge i_clk);

        // Load that never gets a ready: timeout after MaxWait cycles.
        i_valid = 1'b1; i_alu_result = 32'h0000_0100; i_mem_ren = 1'b1; i_mem_wen = 1'b0;
        i_funct3 = 3'd2; i_rd_addr = 5'd4; i_rd_wen = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        for (int c = 0; c < int'(MaxWait); c++) begin
            check_eq("to_req_held", o_dmem_req, 1);
            check_eq("to_no_err", o_err, 0);
            @(negedge i_clk);
        end
        check_eq("to_err", o_err, 1);
        check_eq("to_req_drop", o_dmem_req, 0);
        check_eq("to_no_rd", o_rd_wen, 0);
        @(negedge i_clk);
        check_eq("to_err_pulse", o_err, 0);
        check_eq("to_idle", o_ready, 1);
        check_eq("to_no_rd2", o_rd_wen, 0);

        // Reset while waiting for read data; the late rvalid must not write rd.
        i_valid = 1'b1; i_alu_result = 32'h0000_0300; i_funct3 = 3'd2;
        @(negedge i_clk);
        i_valid = 1'b0; i_dmem_ready = 1'b1;
        @(negedge i_clk);
        i_dmem_ready = 1'b0;
        check_eq("wait_no_req", o_dmem_req, 0);
        check_eq("wait_busy", o_ready, 0);
        i_rst = 1'b1;
        #1;
        check_eq("rst_async_ready", o_ready, 1);
        check_eq("rst_async_addr", o_dmem_addr, 0);
        check_eq("rst_async_mask", o_dmem_mask, 0);
        check_eq("rst_async_wdata", o_rd_wdata, 0);
        check_eq("rst_async_waddr", o_rd_waddr, 0);
        @(negedge i_clk);
        i_rst = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h5555_AAAA;
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_eq("rst_late_rvalid", o_rd_wen, 0);
            @(negedge i_clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
